// File: rtl/pipe_hazard_ctrl.sv
// Central hazard / sequencing controller for the 5-stage FE/DE/EX/ME/WB pipeline.
// Generates stage enables and clears, EX operand forwarding selects, load-use
// stalls, taken-branch flushes, a data-memory wait freeze with a watchdog,
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rd_me,
    input  logic [4:0]       rd_wb,
    input  logic             RuWr_ex,
    input  logic             RuWr_me,
    input  logic             RuWr_wb,
    input  logic             DMRd_ex,
    input  logic             NextPCSrc,
    input  logic             dm_req_me,
    input  logic             dm_ack,
    output logic             en_pc_fe,
    output logic             en_de,
    output logic             flush_de,
    output logic             en_ex,
    output logic             clr,
    output logic             en_me,
    output logic             wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [TO_W-1:0]  TIMEOUT    = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0]  TIMEOUT_M1 = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_stall;

    assign load_use  = DMRd_ex && RuWr_ex && (rd_ex != 5'd0) &&
                       ((rd_ex == rs1_de) || (rd_ex == rs2_de));
    assign mem_stall = dm_req_me && !dm_ack;

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Operand forwarding for EX: the younger ME result wins over WB; x0 never forwards
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (RuWr_me && (rd_me != 5'd0) && (rd_me == rs1_ex))
            fwd_a = 2'b01;
        else if (RuWr_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex))
            fwd_a = 2'b10;
        if (RuWr_me && (rd_me != 5'd0) && (rd_me == rs2_ex))
            fwd_b = 2'b01;
        else if (RuWr_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex))
            fwd_b = 2'b10;
        // Outputs sit at their idle values while reset is asserted
        if (!rst_n) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    // Next-state, counters and stage control; memory freeze beats branch beats load-use
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        en_pc_fe    = 1'b1;
        en_de       = 1'b1;
        flush_de    = 1'b0;
        en_ex       = 1'b1;
        clr         = 1'b0;
        en_me       = 1'b1;
        wb_bubble   = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    en_pc_fe  = 1'b0;
                    en_de     = 1'b0;
                    en_ex     = 1'b0;
                    en_me     = 1'b0;
                    wb_bubble = 1'b1;
                    state_d   = MEM_WAIT;
                    wait_d    = TO_W'(1);
                end else if (NextPCSrc) begin
                    // DE is squashed, so any load-use against it is moot
                    flush_de = 1'b1;
                    clr      = 1'b1;
                    if (flush_cnt_q != CNT_MAX)
                        flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end else if (load_use) begin
                    // One bubble: the load moves to ME next cycle, clearing the hazard
                    en_pc_fe = 1'b0;
                    en_de    = 1'b0;
                    clr      = 1'b1;
                    if (stall_cnt_q != CNT_MAX)
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (stall_cnt_q != CNT_MAX)
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                if (dm_ack) begin
                    // Completing access advances; whole pipe released this cycle
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    en_pc_fe  = 1'b0;
                    en_de     = 1'b0;
                    en_ex     = 1'b0;
                    en_me     = 1'b0;
                    wb_bubble = 1'b1;
                    if (wait_q != TIMEOUT)
                        wait_d = wait_q + TO_W'(1);
                    if (wait_q >= TIMEOUT_M1)
                        mem_err_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase

        if (!rst_n) begin
            en_pc_fe  = 1'b1;
            en_de     = 1'b1;
            flush_de  = 1'b0;
            en_ex     = 1'b1;
            clr       = 1'b0;
            en_me     = 1'b1;
            wb_bubble = 1'b0;
        end
    end

    // State, watchdog and performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences (memory wait, watchdog, reset mid-wait, saturation),
// and randomized traffic checked against a behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 64;
    localparam int TO_W        = 7;
    localparam int CMAX        = (1 << CNT_W) - 1;

    localparam logic [6:0] C_IDLE   = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_LDUSE  = 7'b0001110;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [4:0] rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
    logic RuWr_ex, RuWr_me, RuWr_wb, DMRd_ex, NextPCSrc, dm_req_me, dm_ack;
    logic en_pc_fe, en_de, flush_de, en_ex, clr, en_me, wb_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: waiting flag, cycles spent frozen, sticky error, counters
    bit m_wait;
    int m_frozen;
    bit m_err;
    int m_stall;
    int m_flush;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .rd_me(rd_me), .rd_wb(rd_wb),
        .RuWr_ex(RuWr_ex), .RuWr_me(RuWr_me), .RuWr_wb(RuWr_wb),
        .DMRd_ex(DMRd_ex), .NextPCSrc(NextPCSrc),
        .dm_req_me(dm_req_me), .dm_ack(dm_ack),
        .en_pc_fe(en_pc_fe), .en_de(en_de), .flush_de(flush_de), .en_ex(en_ex),
        .clr(clr), .en_me(en_me), .wb_bubble(wb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
        logic ruwr_ex, ruwr_me, ruwr_wb, dmrd, npc, req, ack;
        logic [6:0] exp_ctrl;
        logic [3:0] exp_fwd;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [6:0] ctrl_now();
        return {en_pc_fe, en_de, flush_de, en_ex, clr, en_me, wb_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs != 0 && RuWr_me && rd_me == rs) return 2'b01;
        if (rs != 0 && RuWr_wb && rd_wb == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_load_use();
        return DMRd_ex && RuWr_ex && rd_ex != 0 && (rd_ex == rs1_de || rd_ex == rs2_de);
    endfunction

    // Expected stage controls from the pipeline rules: freeze, release, flush, bubble, idle
    function automatic logic [6:0] ref_ctrl();
        if (m_wait) return dm_ack ? C_IDLE : C_FREEZE;
        if (dm_req_me && !dm_ack) return C_FREEZE;
        if (NextPCSrc) return C_BRANCH;
        if (ref_load_use()) return C_LDUSE;
        return C_IDLE;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_frozen = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    // Advance the model by one clock with the inputs currently applied
    task automatic model_step();
        if (m_wait) begin
            m_stall = sat_inc(m_stall);
            if (dm_ack) begin
                m_wait = 0;
                m_frozen = 0;
            end else begin
                m_frozen++;
                if (m_frozen >= MEM_TIMEOUT) m_err = 1;
            end
        end else if (dm_req_me && !dm_ack) begin
            m_wait = 1;
            m_frozen = 1;
        end else if (NextPCSrc) begin
            m_flush = sat_inc(m_flush);
        end else if (ref_load_use()) begin
            m_stall = sat_inc(m_stall);
        end
    endtask

    // One clock: compare at negedge against the model (and optional table values), then clock
    task automatic cycle(input bit use_tbl, input logic [6:0] t_ctrl, input logic [3:0] t_fwd);
        @(negedge clk);
        check("ctrl", 32'(ctrl_now()), 32'(ref_ctrl()));
        check("fwd", 32'({fwd_a, fwd_b}), 32'({ref_fwd(rs1_ex), ref_fwd(rs2_ex)}));
        check("mem_err", 32'(mem_err), 32'(m_err));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        if (use_tbl) begin
            check("tbl_ctrl", 32'(ctrl_now()), 32'(t_ctrl));
            check("tbl_fwd", 32'({fwd_a, fwd_b}), 32'(t_fwd));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        rs1_de = 0; rs2_de = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_me = 0; rd_wb = 0;
        RuWr_ex = 0; RuWr_me = 0; RuWr_wb = 0; DMRd_ex = 0; NextPCSrc = 0;
        dm_req_me = 0; dm_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
        check("rst_fwd", 32'({fwd_a, fwd_b}), 32'(0));
        check("rst_cnts", 32'({mem_err, stall_cnt, flush_cnt}), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic apply_vec(input vec_t v);
        rs1_de = v.rs1_de; rs2_de = v.rs2_de; rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex;
        rd_ex = v.rd_ex; rd_me = v.rd_me; rd_wb = v.rd_wb;
        RuWr_ex = v.ruwr_ex; RuWr_me = v.ruwr_me; RuWr_wb = v.ruwr_wb;
        DMRd_ex = v.dmrd; NextPCSrc = v.npc; dm_req_me = v.req; dm_ack = v.ack;
    endtask

    initial begin
        // Directed single-cycle vectors, all applied from the RUN state
        for (int i = 0; i < 12; i++) tbl[i] = '{default: '0};
        tbl[0] = '{rs1_ex:5, rs2_ex:5, rd_me:5, rd_wb:5, ruwr_me:1, ruwr_wb:1,
                   exp_ctrl:C_IDLE, exp_fwd:4'b0101, default:'0};
        tbl[1] = '{rs1_ex:5, rs2_ex:5, rd_me:0, rd_wb:5, ruwr_me:1, ruwr_wb:1,
                   exp_ctrl:C_IDLE, exp_fwd:4'b1010, default:'0};
        tbl[2] = '{rs1_ex:5, rs2_ex:5, rd_me:0, rd_wb:0, ruwr_me:1, ruwr_wb:1,
                   exp_ctrl:C_IDLE, exp_fwd:4'b0000, default:'0};
        tbl[3] = '{rs1_ex:3, rs2_ex:4, rd_me:3, rd_wb:4, ruwr_me:1, ruwr_wb:1,
                   exp_ctrl:C_IDLE, exp_fwd:4'b0110, default:'0};
        tbl[4] = '{rs1_ex:5, rs2_ex:6, rd_me:5, rd_wb:9, ruwr_me:0, ruwr_wb:1,
                   exp_ctrl:C_IDLE, exp_fwd:4'b0000, default:'0};
        tbl[5] = '{rs2_de:7, rd_ex:7, ruwr_ex:1, dmrd:1, exp_ctrl:C_LDUSE, exp_fwd:0, default:'0};
        tbl[6] = '{rs2_de:7, rd_ex:0, ruwr_ex:1, dmrd:1, exp_ctrl:C_IDLE, exp_fwd:0, default:'0};
        tbl[7] = '{rs1_de:7, rd_ex:7, ruwr_ex:1, dmrd:1, npc:1, exp_ctrl:C_BRANCH, exp_fwd:0, default:'0};
        tbl[8] = '{rs1_de:7, rd_ex:7, ruwr_ex:0, dmrd:1, exp_ctrl:C_IDLE, exp_fwd:0, default:'0};
        tbl[9] = '{req:1, ack:1, exp_ctrl:C_IDLE, exp_fwd:0, default:'0};
        tbl[10] = '{ack:1, exp_ctrl:C_IDLE, exp_fwd:0, default:'0};
        tbl[11] = '{npc:1, exp_ctrl:C_BRANCH, exp_fwd:0, default:'0};

        clear_inputs();
        model_reset();
        #2;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i]);
            cycle(1'b1, tbl[i].exp_ctrl, tbl[i].exp_fwd);
            $display("vector %0d: ctrl=%b fwd=%b%b stall=%0d flush=%0d",
                     i, ctrl_now(), fwd_a, fwd_b, stall_cnt, flush_cnt);
        end
        clear_inputs();
        check("tbl_stall_total", 32'(stall_cnt), 32'(1));
        check("tbl_flush_total", 32'(flush_cnt), 32'(2));

        // Load-use with a simultaneous taken branch: flush only
        do_reset();
        rs2_de = 7; rd_ex = 7; RuWr_ex = 1; DMRd_ex = 1; NextPCSrc = 1;
        cycle(1'b1, C_BRANCH, 4'b0000);
        clear_inputs();
        check("lu_br_flush", 32'(flush_cnt), 32'(1));
        check("lu_br_stall", 32'(stall_cnt), 32'(0));

        // Memory access held three cycles, then acknowledged
        do_reset();
        dm_req_me = 1; dm_ack = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, C_FREEZE, 4'b0000);
        dm_ack = 1;
        cycle(1'b1, C_IDLE, 4'b0000);
        clear_inputs();
        cycle(1'b1, C_IDLE, 4'b0000);
        check("memwait_stall", 32'(stall_cnt), 32'(3));

        // Watchdog: ack never arrives
        do_reset();
        dm_req_me = 1; dm_ack = 0;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) cycle(1'b0, 7'd0, 4'd0);
        check("wd_before", 32'(mem_err), 32'(0));
        cycle(1'b0, 7'd0, 4'd0);
        check("wd_rise", 32'(mem_err), 32'(1));
        for (int i = 0; i < 5; i++) cycle(1'b1, C_FREEZE, 4'b0000);
        check("wd_sticky", 32'(mem_err), 32'(1));
        // Reset mid-wait takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_err", 32'(mem_err), 32'(0));
        check("midrst_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
        check("midrst_cnt", 32'(stall_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_inputs();
        cycle(1'b1, C_IDLE, 4'b0000);

        // Counter saturation: 20 load-use events on a 4-bit counter
        do_reset();
        rs1_de = 9; rd_ex = 9; RuWr_ex = 1; DMRd_ex = 1;
        for (int i = 0; i < 20; i++) cycle(1'b1, C_LDUSE, 4'b0000);
        check("stall_sat", 32'(stall_cnt), 32'(15));
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            NextPCSrc = 1;
            cycle(1'b1, C_BRANCH, 4'b0000);
        end
        check("flush_sat", 32'(flush_cnt), 32'(15));
        clear_inputs();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) do_reset();
            rs1_de = 5'($urandom_range(0, 3)); rs2_de = 5'($urandom_range(0, 3));
            rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
            rd_ex  = 5'($urandom_range(0, 3)); rd_me  = 5'($urandom_range(0, 3));
            rd_wb  = 5'($urandom_range(0, 3));
            RuWr_ex = 1'($urandom_range(0, 1)); RuWr_me = 1'($urandom_range(0, 1));
            RuWr_wb = 1'($urandom_range(0, 1)); DMRd_ex = 1'($urandom_range(0, 1));
            NextPCSrc = ($urandom_range(0, 3) == 0);
            dm_req_me = ($urandom_range(0, 2) == 0);
            dm_ack = ($urandom_range(0, 3) == 0);
            cycle(1'b0, 7'd0, 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage segmented RISC-V datapath (FE/DE/EX/ME/WB). It produces all stage-register enables and clears, and detects load-use stalls and taken-branch flushes. It selects operand forwarding for EX and freezes the pipeline while a variable-latency data memory completes an access. It replaces the ad-hoc hazard logic scattered in DE/EX, and adds a watchdog and performance counters.

Parameters:
CNT_W, 32, width of stall/flush performance counters (saturating)
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before mem_err is raised (>=2)
TO_W, 7, width of the wait-cycle counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_de, rs2_de  in  5 each  source registers of instruction in DE
rs1_ex, rs2_ex, rd_ex  in  5 each  register fields in EX
rd_me, rd_wb  in  5 each  destination registers in ME / WB
RuWr_ex, RuWr_me, RuWr_wb  in  1 each  register-write enables per stage
DMRd_ex  in  1  instruction in EX is a load
NextPCSrc  in  1  taken branch/jump resolved in EX
dm_req_me  in  1  ME stage issues a data-memory access this cycle
dm_ack  in  1  data memory completes the access (may be same cycle as req)
en_pc_fe  out  1  PC register enable
en_de  out  1  FE/DE register enable
flush_de  out  1  synchronous clear of FE/DE register
en_ex  out  1  DE/EX register enable
clr  out  1  synchronous clear of DE/EX register (bubble)
en_me  out  1  EX/ME register enable
wb_bubble  out  1  ME/WB register loads RuWr=0 (bubble)
fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 ALU result in ME, 10 muxData from WB
mem_err  out  1  sticky watchdog timeout flag
stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_n=0, async): state=RUN, wait counter=0, mem_err=0, both counters=0. Outputs held at: all enables=1, flush_de=0, clr=0, wb_bubble=0, fwd_a=fwd_b=00.
- Forwarding (combinational, every state): fwd_a=01 if RuWr_me && rd_me!=0 && rd_me==rs1_ex; else 10 if RuWr_wb && rd_wb!=0 && rd_wb==rs1_ex; else 00. fwd_b is the same using rs2_ex. The ME source takes priority over WB.
- load_use = DMRd_ex && RuWr_ex && rd_ex!=0 && (rd_ex==rs1_de || rd_ex==rs2_de).
- mem_stall = dm_req_me && !dm_ack.
- Priority within a cycle: mem_stall > NextPCSrc > load_use.
- State RUN:
  - If mem_stall: en_pc_fe=en_de=en_ex=en_me=0, wb_bubble=1, clr=0, flush_de=0. Next state=MEM_WAIT, wait counter=1.
  - Else if NextPCSrc: flush_de=1, clr=1, all enables=1. flush_cnt+1. The load_use condition is ignored, because the instruction in DE is squashed.
  - Else if load_use: en_pc_fe=0, en_de=0, clr=1, en_ex=1, en_me=1. stall_cnt+1. The condition clears by itself next cycle because the load advances to ME. This gives exactly one bubble.
  - Else: default outputs.
- State MEM_WAIT:
  - Outputs are frozen exactly as in the RUN mem_stall case. NextPCSrc and load_use are ignored, since EX is held and is re-evaluated on exit. stall_cnt+1 each cycle.
  - On dm_ack=1: the outputs this cycle are still the frozen set except en_me=1, wb_bubble=0, en_pc_fe=en_de=en_ex=1. The completing access advances. Next state=RUN, wait counter=0.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, mem_err is set (sticky until reset) and the FSM stays in MEM_WAIT. The counter saturates.
- Counters saturate at all-ones and never wrap.
- rs/rd field value 0 never creates a hazard or a forward.
- dm_ack without dm_req_me in RUN is ignored.
- Reset asserted mid-MEM_WAIT returns to RUN immediately, with all outputs at their reset values.

Test Plan:
- ME: add x5 (RuWr_me=1, rd_me=5), EX: rs1_ex=5, rs2_ex=5; WB also writes x5 -> fwd_a=fwd_b=01 (ME wins). Repeat with rd_me=0 -> fwd=10. With rd_wb=0 as well -> 00.
- DMRd_ex=1, RuWr_ex=1, rd_ex=7, rs2_de=7 for one cycle -> en_pc_fe=0, en_de=0, clr=1 in that cycle only; stall_cnt=1. Same stimulus with rd_ex=0 -> no stall.
- Load-use and NextPCSrc=1 in the same cycle -> flush_de=1, clr=1, en_pc_fe=1; flush_cnt=1, stall_cnt=0.
- dm_req_me=1, dm_ack low for 3 cycles then high -> 3 frozen cycles with wb_bubble=1, then the release cycle with en_me=1; back to RUN; stall_cnt=3. dm_req_me=dm_ack=1 in the same cycle -> no freeze.
- dm_ack held low for MEM_TIMEOUT cycles -> mem_err rises at count 64 and stays high. Asserting rst_n=0 mid-wait -> immediate RUN, mem_err=0, counters=0.
- Force stall_cnt near all-ones (CNT_W=4 build), then 20 load-use events -> stall_cnt holds at 15.
